// File: rtl/video_pkg.sv
// video_pkg: shared types, widths and checksum step for the video monitors
package video_pkg;
    typedef enum logic {WAIT_SYNC, IN_FRAME} state_e;
    localparam int CHK_W = 32;
    localparam int FCNT_W = 16;
    function automatic logic [CHK_W-1:0] chk_step(input logic [CHK_W-1:0] s, input logic [CHK_W-1:0] px);
        return {s[CHK_W-2:0], s[CHK_W-1]} ^ px;
    endfunction
endpackage

// File: rtl/hdmi_line_counter.sv
// hdmi_line_counter: per-frame pixel/line counting, first-line width and line-length error
module hdmi_line_counter #(
    parameter int H_RES = 1280,
    parameter int CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             pix_en_i,
    input  logic             close_i,
    output logic [CNT_W-1:0] lines_o,
    output logic [CNT_W-1:0] first_h_o,
    output logic             h_acc_o
);
    logic [CNT_W-1:0] pix_q, pix_d, line_q, line_d, first_q, first_d;
    logic h_acc_q, h_acc_d;
    // Outputs are next-state values so a line closed on the frame-end edge is included
    always_comb begin
        pix_d = close_i ? '0 : pix_q + CNT_W'(pix_en_i & ~&pix_q);
        line_d = line_q + CNT_W'(close_i & ~&line_q);
        first_d = (close_i && line_q == '0) ? pix_q : first_q;
        h_acc_d = h_acc_q | (close_i && pix_q != CNT_W'(H_RES));
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            pix_q <= '0;
            line_q <= '0;
            first_q <= '0;
            h_acc_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
            line_q <= line_d;
            first_q <= first_d;
            h_acc_q <= h_acc_d;
        end
    end
    assign lines_o = line_d;
    assign first_h_o = first_d;
    assign h_acc_o = h_acc_d;
endmodule

// File: rtl/hdmi_frame_monitor.sv
// hdmi_frame_monitor: measures frame geometry, checks it and folds a per-frame checksum
module hdmi_frame_monitor
    import video_pkg::*;
#(
    parameter int H_RES = 1280,
    parameter int V_RES = 720,
    parameter int DATA_W = 24,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int CNT_W = 12
) (
    input  logic              hdmi_clk,
    input  logic              hdmi_rst_n,
    input  logic              hdmi_vs,
    input  logic              hdmi_de,
    input  logic [DATA_W-1:0] hdmi_data,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              h_err,
    output logic              v_err,
    output logic              de_in_vs_err,
    output logic [CNT_W-1:0]  meas_h,
    output logic [CNT_W-1:0]  meas_v,
    output logic [CHK_W-1:0]  checksum,
    output logic [FCNT_W-1:0] frame_cnt
);
    state_e state_q;
    logic vs_d_q, de_d_q, vs_acc_q;
    logic [CHK_W-1:0] sum_q;
    logic vs_act, vs_rise, de_fall, in_frame, frame_end, pix_en, line_close, lc_clr;
    logic [CNT_W-1:0] lines, first_h;
    logic h_acc;
    always_comb begin
        vs_act = hdmi_vs ^ (VS_ACTIVE_LOW != 0);
        vs_rise = vs_act & ~vs_d_q;
        de_fall = ~hdmi_de & de_d_q;
        in_frame = state_q == IN_FRAME;
        frame_end = in_frame & vs_rise;
        pix_en = in_frame & hdmi_de & ~vs_act;
        line_close = in_frame & (de_fall | (vs_rise & de_d_q));
        lc_clr = ~in_frame | frame_end;
    end
    hdmi_line_counter #(.H_RES(H_RES), .CNT_W(CNT_W)) u_lines (
        .clk_i(hdmi_clk),
        .rst_n_i(hdmi_rst_n),
        .clr_i(lc_clr),
        .pix_en_i(pix_en),
        .close_i(line_close),
        .lines_o(lines),
        .first_h_o(first_h),
        .h_acc_o(h_acc)
    );
    always_ff @(posedge hdmi_clk) begin
        if (!hdmi_rst_n) begin
            state_q <= WAIT_SYNC;
            vs_d_q <= 1'b1;
            de_d_q <= 1'b0;
            vs_acc_q <= 1'b0;
            sum_q <= '0;
            frame_done <= 1'b0;
            frame_ok <= 1'b0;
            h_err <= 1'b0;
            v_err <= 1'b0;
            de_in_vs_err <= 1'b0;
            meas_h <= '0;
            meas_v <= '0;
            checksum <= '0;
            frame_cnt <= '0;
        end else begin
            vs_d_q <= vs_act;
            de_d_q <= hdmi_de;
            frame_done <= frame_end;
            if (vs_rise)
                state_q <= IN_FRAME;
            sum_q <= lc_clr ? '0 : pix_en ? chk_step(sum_q, CHK_W'(hdmi_data)) : sum_q;
            // A pixel on the vs_rise cycle belongs to the new frame's de-in-VS flag
            vs_acc_q <= vs_rise ? hdmi_de : in_frame & (vs_acc_q | (hdmi_de & vs_act));
            if (frame_end) begin
                meas_h <= first_h;
                meas_v <= lines;
                checksum <= sum_q;
                h_err <= h_acc;
                v_err <= lines != CNT_W'(V_RES);
                de_in_vs_err <= vs_acc_q;
                frame_ok <= !(h_acc || lines != CNT_W'(V_RES) || vs_acc_q) && lines != '0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_frame_monitor.sv
// tb_hdmi_frame_monitor: directed checks of both VS polarities against hand-derived results
module tb_hdmi_frame_monitor;
    localparam int H = 4;
    localparam int V = 3;
    localparam int DW = 24;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsa = 1'b0;
    logic de = 1'b0;
    logic [DW-1:0] data = '0;
    logic fd1, ok1, he1, ve1, dv1, fd0, ok0, he0, ve0, dv0;
    logic [CW-1:0] mh1, mv1, mh0, mv0;
    logic [31:0] cs1, cs0, cs12;
    logic [15:0] fc1, fc0;
    logic [60:0] st1, st0;
    int checks = 0;
    int errors = 0;
    int p1 = 0;
    int p0 = 0;
    always #5 clk = ~clk;
    hdmi_frame_monitor #(.H_RES(H), .V_RES(V), .DATA_W(DW), .VS_ACTIVE_LOW(1), .CNT_W(CW)) dut1 (
        .hdmi_clk(clk), .hdmi_rst_n(rst_n), .hdmi_vs(~vsa), .hdmi_de(de), .hdmi_data(data),
        .frame_done(fd1), .frame_ok(ok1), .h_err(he1), .v_err(ve1), .de_in_vs_err(dv1),
        .meas_h(mh1), .meas_v(mv1), .checksum(cs1), .frame_cnt(fc1)
    );
    hdmi_frame_monitor #(.H_RES(H), .V_RES(V), .DATA_W(DW), .VS_ACTIVE_LOW(0), .CNT_W(CW)) dut0 (
        .hdmi_clk(clk), .hdmi_rst_n(rst_n), .hdmi_vs(vsa), .hdmi_de(de), .hdmi_data(data),
        .frame_done(fd0), .frame_ok(ok0), .h_err(he0), .v_err(ve0), .de_in_vs_err(dv0),
        .meas_h(mh0), .meas_v(mv0), .checksum(cs0), .frame_cnt(fc0)
    );
    assign st1 = {fd1, ok1, he1, ve1, dv1, mh1, mv1, cs1, fc1};
    assign st0 = {fd0, ok0, he0, ve0, dv0, mh0, mv0, cs0, fc0};
    always @(negedge clk) begin
        if (fd1) p1++;
        if (fd0) p0++;
    end
    function automatic logic [31:0] fold(input int first, input int n);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < n; i++)
            s = {s[30:0], s[31]} ^ 32'(first + i);
        return s;
    endfunction
    task automatic cyc(input logic v, input logic e, input logic [DW-1:0] d);
        vsa = v;
        de = e;
        data = d;
        @(posedge clk);
        #1;
    endtask
    task automatic line(input int n, input int base, input int step);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b1, DW'(base + i * step));
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
    endtask
    task automatic zframe();
        for (int i = 0; i < 3; i++)
            line(4, 0, 0);
    endtask
    task automatic expect_st(input string tag, input logic fd, input logic ok, input logic he,
                             input logic ve, input logic dv, input logic [3:0] mh, input logic [3:0] mv,
                             input logic [31:0] cs, input logic [15:0] fc);
        logic [60:0] e;
        e = {fd, ok, he, ve, dv, mh, mv, cs, fc};
        checks++;
        assert (st1 === e) else begin
            errors++;
            $error("FAIL %s vs_low=1 got %h exp %h", tag, st1, e);
        end
        checks++;
        assert (st0 === e) else begin
            errors++;
            $error("FAIL %s vs_low=0 got %h exp %h", tag, st0, e);
        end
    endtask
    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    initial begin
        cs12 = fold(1, 12);
        repeat (3) cyc(1'b0, 1'b0, '0);
        expect_st("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        line(4, 0, 0);
        line(4, 0, 0);
        cyc(1'b1, 1'b0, '0);
        expect_st("partial", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b0, '0);
        zframe();
        cyc(1'b1, 1'b0, '0);
        expect_st("clean_a", 1, 1, 0, 0, 0, 4, 3, 0, 1);
        cyc(1'b0, 1'b0, '0);
        expect_st("pulse_one", 0, 1, 0, 0, 0, 4, 3, 0, 1);
        zframe();
        cyc(1'b1, 1'b0, '0);
        expect_st("clean_b", 1, 1, 0, 0, 0, 4, 3, 0, 2);
        cyc(1'b0, 1'b0, '0);
        chk_int("pulses_a1", p1, 2);
        chk_int("pulses_a0", p0, 2);
        line(4, 1, 1);
        line(4, 5, 1);
        line(4, 9, 1);
        expect_st("sum_latency", 0, 1, 0, 0, 0, 4, 3, 0, 2);
        cyc(1'b1, 1'b0, '0);
        expect_st("sum", 1, 1, 0, 0, 0, 4, 3, cs12, 3);
        cyc(1'b0, 1'b0, '0);
        line(4, 0, 0);
        line(5, 0, 0);
        line(4, 0, 0);
        cyc(1'b1, 1'b0, '0);
        expect_st("h_err", 1, 0, 1, 0, 0, 4, 3, 0, 4);
        cyc(1'b0, 1'b0, '0);
        zframe();
        cyc(1'b1, 1'b0, '0);
        expect_st("recover", 1, 1, 0, 0, 0, 4, 3, 0, 5);
        cyc(1'b0, 1'b0, '0);
        line(4, 0, 0);
        line(4, 0, 0);
        cyc(1'b1, 1'b0, '0);
        expect_st("v_err", 1, 0, 0, 1, 0, 4, 2, 0, 6);
        cyc(1'b0, 1'b0, '0);
        line(4, 0, 0);
        line(4, 0, 0);
        repeat (4) cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 24'h77);
        expect_st("open_line", 1, 1, 0, 0, 0, 4, 3, 0, 7);
        cyc(1'b1, 1'b1, 24'h77);
        for (int i = 1; i <= 4; i++)
            cyc(1'b0, 1'b1, DW'(i));
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        line(4, 5, 1);
        line(4, 9, 1);
        cyc(1'b1, 1'b0, '0);
        expect_st("de_in_vs", 1, 0, 0, 0, 1, 4, 3, cs12, 8);
        cyc(1'b0, 1'b0, '0);
        zframe();
        cyc(1'b1, 1'b0, '0);
        expect_st("clean_c", 1, 1, 0, 0, 0, 4, 3, 0, 9);
        cyc(1'b0, 1'b0, '0);
        line(4, 1, 1);
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, '0);
        rst_n = 1'b1;
        expect_st("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        line(4, 1, 1);
        line(4, 1, 1);
        cyc(1'b1, 1'b0, '0);
        expect_st("post_reset_sync", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b0, '0);
        zframe();
        cyc(1'b1, 1'b0, '0);
        expect_st("resume", 1, 1, 0, 0, 0, 4, 3, 0, 1);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        expect_st("zero_lines", 1, 0, 0, 1, 0, 0, 0, 0, 2);
        cyc(1'b0, 1'b0, '0);
        chk_int("pulses_total1", p1, 11);
        chk_int("pulses_total0", p0, 11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
